// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller.
//   - state encodings S_IF..S_J (ST_ENC_W bits)
//   - supported opcode constants
//   - ALUOp / ALUSrcB / PCSource select encodings
//   - ctrl_t: the control word produced for one state
package mc_ctrl_pkg;

    localparam int ST_ENC_W = 4;
    typedef logic [ST_ENC_W-1:0] state_t;

    localparam state_t S_IF       = 4'd0;
    localparam state_t S_ID       = 4'd1;
    localparam state_t S_MEM_ADDR = 4'd2;
    localparam state_t S_MEM_RD   = 4'd3;
    localparam state_t S_MEM_WB   = 4'd4;
    localparam state_t S_MEM_WR   = 4'd5;
    localparam state_t S_R_EX     = 4'd6;
    localparam state_t S_R_WB     = 4'd7;
    localparam state_t S_ADDI_EX  = 4'd8;
    localparam state_t S_ADDI_WB  = 4'd9;
    localparam state_t S_BR       = 4'd10;
    localparam state_t S_J        = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Combinational control-word decode for the multi-cycle controller.
// Ports:
//   state    in  current controller state
//   opcode   in  IR[31:26] (selects bne semantics and flags illegal opcodes in ID)
//   mem_rdy  in  effective memory-ready (already forced to 1 when handshake unused)
//   ctrl     out control word for this state; all-zero for unused encodings
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_rdy,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // IR and PC+4 only commit on the cycle the fetch completes
                ctrl.ir_write  = mem_rdy;
                ctrl.pc_write  = mem_rdy;
            end
            S_ID: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.illegal_op = !(opcode == OP_R   || opcode == OP_LW  ||
                                    opcode == OP_SW  || opcode == OP_BEQ ||
                                    opcode == OP_BNE || opcode == OP_J   ||
                                    opcode == OP_ADDI);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.branch_ne     = (opcode == OP_BNE);
            end
            S_J: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore-style main controller for the multi-cycle MIPS datapath.
// Steps each instruction through IF/ID/EX/MEM/WB and drives all datapath
// enables and mux selects; waits on the unified memory's mem_ready.
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   opcode           IR[31:26]
//   zero             ALU zero flag, meaningful in the branch state
//   mem_ready        memory completes the current access this cycle
//   pc_wre           PC load enable (unconditional or taken branch)
//   pc_write .. pc_source, illegal_op   datapath control word
//   state            current state (debug)
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int STATE_W       = ST_ENC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_wre,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  dec_ctrl;
    ctrl_t  ctrl;
    logic   mem_rdy;

    assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:       state_d = mem_rdy ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_R:           state_d = S_R_EX;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_J;
                    OP_ADDI:        state_d = S_ADDI_EX;
                    default:        state_d = S_IF;
                endcase
            end
            // Only lw/sw reach address calculation, so anything but lw is a store
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_rdy ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_rdy ? S_IF : S_MEM_WR;
            S_R_EX:     state_d = S_R_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            default:    state_d = S_IF;
        endcase
    end

    mc_ctrl_out_decode u_decode (
        .state   (state_q),
        .opcode  (opcode),
        .mem_rdy (mem_rdy),
        .ctrl    (dec_ctrl)
    );

    // Reset silences every strobe immediately, including mid-access memory waits
    always_comb begin
        ctrl = dec_ctrl;
        if (rst) ctrl = '0;
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;

    // branch_ne flips the sense of zero so one term covers beq and bne
    assign pc_wre = ctrl.pc_write | (ctrl.pc_write_cond & (zero ^ ctrl.branch_ne));

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm. Instruction-level scripts
// describe the cycles each instruction should take and the control word seen
// in each; the stimulus side queues those records, a monitor compares them.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_wre;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       z;
        logic [5:0] op;
        logic [3:0] st;
        obs_t       c;
    } rec_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_wre, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int   vectors = 0;
    int   miscompares = 0;
    rec_t sbq[$];
    logic [5:0] cur_op;

    mc_control_fsm #(.USE_MEM_READY(1), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_wre(pc_wre), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_ne(branch_ne), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sbq.size());
        $fatal(1, "watchdog");
    end

    // Monitor: one record per cycle, compared at the falling edge
    always @(negedge clk) begin
        rec_t r;
        obs_t a;
        if (sbq.size() > 0) begin
            r = sbq.pop_front();
            a.pc_wre = pc_wre;            a.pc_write = pc_write;
            a.pc_write_cond = pc_write_cond; a.branch_ne = branch_ne;
            a.iord = iord;                a.mem_read = mem_read;
            a.mem_write = mem_write;      a.ir_write = ir_write;
            a.mem_to_reg = mem_to_reg;    a.reg_dst = reg_dst;
            a.reg_write = reg_write;      a.alu_src_a = alu_src_a;
            a.alu_src_b = alu_src_b;      a.alu_op = alu_op;
            a.pc_source = pc_source;      a.illegal_op = illegal_op;
            vectors++;
            if (state !== r.st) begin
                miscompares++;
                $display("FAIL state op=%b rst=%0d: got %0d expected %0d", r.op, r.rst, state, r.st);
            end
            vectors++;
            if (a !== r.c) begin
                miscompares++;
                $display("FAIL ctrl st=%0d op=%b mr=%0d z=%0d rst=%0d: got %h expected %h",
                         r.st, r.op, r.mr, r.z, r.rst, a, r.c);
            end
        end
    end

    function automatic bit legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
               op == OP_BNE || op == OP_J || op == OP_ADDI;
    endfunction

    function automatic rec_t mk(input logic [3:0] st);
        rec_t r;
        r = '0;
        r.mr = 1'b1;
        r.z = 1'($urandom_range(0, 1));
        r.op = cur_op;
        r.st = st;
        return r;
    endfunction

    task automatic cyc(input rec_t r);
        rst = r.rst;
        mem_ready = r.mr;
        zero = r.z;
        opcode = r.op;
        sbq.push_back(r);
        @(posedge clk);
        #1;
    endtask

    // Fetch: waits cycles with memory busy, then the completing cycle
    task automatic do_if(input int waits);
        rec_t r;
        for (int i = 0; i < waits; i++) begin
            r = mk(S_IF);
            r.mr = 1'b0;
            r.c.mem_read = 1'b1;
            r.c.alu_src_b = 2'b01;
            cyc(r);
        end
        r = mk(S_IF);
        r.c.mem_read = 1'b1;
        r.c.alu_src_b = 2'b01;
        r.c.ir_write = 1'b1;
        r.c.pc_write = 1'b1;
        r.c.pc_wre = 1'b1;
        cyc(r);
    endtask

    task automatic do_id(input bit bad);
        rec_t r;
        r = mk(S_ID);
        r.c.alu_src_b = 2'b11;
        r.c.illegal_op = bad;
        cyc(r);
    endtask

    task automatic do_addr(input logic [3:0] st);
        rec_t r;
        r = mk(st);
        r.c.alu_src_a = 1'b1;
        r.c.alu_src_b = 2'b10;
        cyc(r);
    endtask

    task automatic do_mem(input logic [3:0] st, input bit wr, input int waits);
        rec_t r;
        for (int i = 0; i <= waits; i++) begin
            r = mk(st);
            r.mr = (i == waits);
            r.c.iord = 1'b1;
            r.c.mem_read = !wr;
            r.c.mem_write = wr;
            cyc(r);
        end
    endtask

    task automatic do_wb(input logic [3:0] st, input bit from_mem, input bit to_rd);
        rec_t r;
        r = mk(st);
        r.c.reg_write = 1'b1;
        r.c.mem_to_reg = from_mem;
        r.c.reg_dst = to_rd;
        cyc(r);
    endtask

    // zf < 0 picks a random zero flag for the branch cycle
    task automatic run_instr(input logic [5:0] op, input int w_if, input int w_mem, input int zf);
        rec_t r;
        cur_op = op;
        do_if(w_if);
        do_id(!legal(op));
        case (op)
            OP_R: begin
                r = mk(S_R_EX);
                r.c.alu_src_a = 1'b1;
                r.c.alu_op = 2'b10;
                cyc(r);
                do_wb(S_R_WB, 1'b0, 1'b1);
            end
            OP_LW: begin
                do_addr(S_MEM_ADDR);
                do_mem(S_MEM_RD, 1'b0, w_mem);
                do_wb(S_MEM_WB, 1'b1, 1'b0);
            end
            OP_SW: begin
                do_addr(S_MEM_ADDR);
                do_mem(S_MEM_WR, 1'b1, w_mem);
            end
            OP_ADDI: begin
                do_addr(S_ADDI_EX);
                do_wb(S_ADDI_WB, 1'b0, 1'b0);
            end
            OP_BEQ, OP_BNE: begin
                r = mk(S_BR);
                if (zf >= 0) r.z = 1'(zf);
                r.c.alu_src_a = 1'b1;
                r.c.alu_op = 2'b01;
                r.c.pc_source = 2'b01;
                r.c.pc_write_cond = 1'b1;
                r.c.branch_ne = (op == OP_BNE);
                // beq is taken on equality, bne on inequality
                r.c.pc_wre = (op == OP_BEQ) ? r.z : !r.z;
                cyc(r);
            end
            OP_J: begin
                r = mk(S_J);
                r.c.pc_write = 1'b1;
                r.c.pc_source = 2'b10;
                r.c.pc_wre = 1'b1;
                cyc(r);
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        rec_t r;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
        cur_op = OP_R;
        rst = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b0;
        opcode = OP_R;
        @(posedge clk);
        #1;

        // Reset held two cycles: state parked in IF, every output low
        for (int i = 0; i < 2; i++) begin
            r = mk(S_IF);
            r.rst = 1'b1;
            cyc(r);
        end

        // Directed cases
        run_instr(OP_R, 0, 0, -1);
        run_instr(OP_LW, 0, 3, -1);
        run_instr(OP_BEQ, 0, 0, 1);
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(OP_BNE, 0, 0, 0);
        run_instr(OP_BNE, 0, 0, 1);
        run_instr(6'b111111, 0, 0, -1);
        run_instr(OP_SW, 1, 2, -1);
        run_instr(OP_J, 0, 0, -1);
        run_instr(OP_ADDI, 2, 0, -1);

        // Randomized instruction stream with random memory latency
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 6)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        // Reset during a stalled store: strobes drop that cycle, fetch resumes
        cur_op = OP_SW;
        do_if(0);
        do_id(1'b0);
        do_addr(S_MEM_ADDR);
        r = mk(S_MEM_WR);
        r.mr = 1'b0;
        r.c.iord = 1'b1;
        r.c.mem_write = 1'b1;
        cyc(r);
        r = mk(S_MEM_WR);
        r.mr = 1'b0;
        r.rst = 1'b1;
        cyc(r);
        run_instr(OP_R, 0, 0, -1);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d records left, expected 0", sbq.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
